// File: rtl/reorder_buffer_pkg.sv
// Shared encodings and default widths for the reorder buffer and its neighbours in ID/EX.
package reorder_buffer_pkg;

  localparam int DEF_ROB_ID_SIZE    = 4;
  localparam int DEF_DEST_ADDR_SIZE = 5;
  localparam int DEF_REG_DATA_WIDTH = 32;
  localparam int DEF_PRED_ADDR_SIZE = 3;
  localparam int DEF_INS_TYPE_SIZE  = 2;
  localparam int INS_STATE_SIZE     = 1;

  // The reserved encoding retires like INS_TYPE_NONE.
  typedef enum logic [1:0] {
    INS_TYPE_NONE = 2'b00,
    INS_TYPE_PRED = 2'b01,
    INS_TYPE_REG  = 2'b10,
    INS_TYPE_RSVD = 2'b11
  } ins_type_e;

endpackage

// File: rtl/rob_entry_ram.sv
// Entry storage for the reorder buffer: allocation write port, completion write port,
// head read port with clear, and per-entry valid/done flags.
module rob_entry_ram
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_ID_SIZE    = DEF_ROB_ID_SIZE,
  parameter int DEST_ADDR_SIZE = DEF_DEST_ADDR_SIZE,
  parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
  parameter int INS_TYPE_SIZE  = DEF_INS_TYPE_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_en,
  input  logic [ROB_ID_SIZE-1:0]    alloc_id,
  input  logic                      alloc_done,
  input  logic [INS_TYPE_SIZE-1:0]  alloc_type,
  input  logic [DEST_ADDR_SIZE-1:0] alloc_dest,
  input  logic                      cmpl_en,
  input  logic [ROB_ID_SIZE-1:0]    cmpl_id,
  input  logic [REG_DATA_WIDTH-1:0] cmpl_reg_data,
  input  logic                      cmpl_pred_data,
  input  logic                      clear_en,
  input  logic [ROB_ID_SIZE-1:0]    rd_id,
  output logic                      rd_valid,
  output logic                      rd_done,
  output logic [INS_TYPE_SIZE-1:0]  rd_type,
  output logic [DEST_ADDR_SIZE-1:0] rd_dest,
  output logic [REG_DATA_WIDTH-1:0] rd_reg_data,
  output logic                      rd_pred_data
);

  localparam int DEPTH = 2 ** ROB_ID_SIZE;

  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0]          done_q;
  logic [INS_TYPE_SIZE-1:0]  type_q     [DEPTH];
  logic [DEST_ADDR_SIZE-1:0] dest_q     [DEPTH];
  logic [REG_DATA_WIDTH-1:0] reg_data_q [DEPTH];
  logic [DEPTH-1:0]          pred_data_q;

  // Entries are fully zeroed on reset and on retirement so an empty head reads as all zeros.
  // Allocation is written last so it wins over anything else aimed at the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      done_q      <= '0;
      pred_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i]     <= '0;
        dest_q[i]     <= '0;
        reg_data_q[i] <= '0;
      end
    end else begin
      if (clear_en) begin
        valid_q[rd_id]     <= 1'b0;
        done_q[rd_id]      <= 1'b0;
        type_q[rd_id]      <= '0;
        dest_q[rd_id]      <= '0;
        reg_data_q[rd_id]  <= '0;
        pred_data_q[rd_id] <= 1'b0;
      end
      if (cmpl_en && valid_q[cmpl_id] && !done_q[cmpl_id]) begin
        done_q[cmpl_id]      <= 1'b1;
        reg_data_q[cmpl_id]  <= cmpl_reg_data;
        pred_data_q[cmpl_id] <= cmpl_pred_data;
      end
      if (alloc_en) begin
        valid_q[alloc_id]     <= 1'b1;
        done_q[alloc_id]      <= alloc_done;
        type_q[alloc_id]      <= alloc_type;
        dest_q[alloc_id]      <= alloc_dest;
        reg_data_q[alloc_id]  <= '0;
        pred_data_q[alloc_id] <= 1'b0;
      end
    end
  end

  assign rd_valid     = valid_q[rd_id];
  assign rd_done      = done_q[rd_id];
  assign rd_type      = type_q[rd_id];
  assign rd_dest      = dest_q[rd_id];
  assign rd_reg_data  = reg_data_q[rd_id];
  assign rd_pred_data = pred_data_q[rd_id];

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates from decode, collects EX completions out of order,
// and retires at most one entry per cycle onto the register and predicate write ports.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_ID_SIZE    = DEF_ROB_ID_SIZE,
  parameter int DEST_ADDR_SIZE = DEF_DEST_ADDR_SIZE,
  parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
  parameter int PRED_ADDR_SIZE = DEF_PRED_ADDR_SIZE,
  parameter int INS_TYPE_SIZE  = DEF_INS_TYPE_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      add_rob_entry,
  input  logic [DEST_ADDR_SIZE-1:0] entry_dest_addr,
  input  logic [INS_TYPE_SIZE-1:0]  entry_ins_type,
  input  logic [INS_STATE_SIZE-1:0] entry_ins_state,
  output logic                      rob_full,
  output logic [ROB_ID_SIZE-1:0]    entry_id,
  input  logic                      ex_done,
  input  logic [ROB_ID_SIZE-1:0]    ex_id,
  input  logic [REG_DATA_WIDTH-1:0] ex_reg_data,
  input  logic                      ex_pred_data,
  output logic                      wr_reg_en,
  output logic [DEST_ADDR_SIZE-1:0] wr_reg_addr,
  output logic [REG_DATA_WIDTH-1:0] wr_reg_data,
  output logic                      wr_pred_en,
  output logic [PRED_ADDR_SIZE-1:0] wr_pred_addr,
  output logic                      wr_pred_data,
  output logic                      rob_empty
);

  localparam logic [ROB_ID_SIZE:0] DEPTH = {1'b1, {ROB_ID_SIZE{1'b0}}};

  logic [ROB_ID_SIZE-1:0]    head;
  logic [ROB_ID_SIZE-1:0]    tail;
  logic [ROB_ID_SIZE:0]      count;
  logic                      alloc;
  logic                      commit;
  logic                      head_valid;
  logic                      head_done;
  logic [INS_TYPE_SIZE-1:0]  head_type;
  logic [DEST_ADDR_SIZE-1:0] head_dest;
  logic [REG_DATA_WIDTH-1:0] head_reg_data;
  logic                      head_pred_data;

  assign rob_full  = (count == DEPTH);
  assign rob_empty = (count == '0);
  assign entry_id  = tail;
  assign alloc     = add_rob_entry & ~rob_full;
  assign commit    = head_valid & head_done;

  rob_entry_ram #(
    .ROB_ID_SIZE   (ROB_ID_SIZE),
    .DEST_ADDR_SIZE(DEST_ADDR_SIZE),
    .REG_DATA_WIDTH(REG_DATA_WIDTH),
    .INS_TYPE_SIZE (INS_TYPE_SIZE)
  ) u_entries (
    .clk           (clk),
    .reset         (reset),
    .alloc_en      (alloc),
    .alloc_id      (tail),
    .alloc_done    (entry_ins_state[0]),
    .alloc_type    (entry_ins_type),
    .alloc_dest    (entry_dest_addr),
    .cmpl_en       (ex_done),
    .cmpl_id       (ex_id),
    .cmpl_reg_data (ex_reg_data),
    .cmpl_pred_data(ex_pred_data),
    .clear_en      (commit),
    .rd_id         (head),
    .rd_valid      (head_valid),
    .rd_done       (head_done),
    .rd_type       (head_type),
    .rd_dest       (head_dest),
    .rd_reg_data   (head_reg_data),
    .rd_pred_data  (head_pred_data)
  );

  // Pointers wrap naturally; count stays put when an allocation and a commit coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc) tail <= tail + 1'b1;
      if (commit) head <= head + 1'b1;
      if (alloc && !commit) count <= count + 1'b1;
      else if (commit && !alloc) count <= count - 1'b1;
    end
  end

  assign wr_reg_en    = commit & (head_type == INS_TYPE_SIZE'(INS_TYPE_REG));
  assign wr_pred_en   = commit & (head_type == INS_TYPE_SIZE'(INS_TYPE_PRED));
  assign wr_reg_addr  = head_dest;
  assign wr_reg_data  = head_reg_data;
  assign wr_pred_addr = head_dest[PRED_ADDR_SIZE-1:0];
  assign wr_pred_data = head_pred_data;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized run
// checked against a queue-based program-order model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        add_rob_entry = 1'b0;
  logic [4:0]  entry_dest_addr = '0;
  logic [1:0]  entry_ins_type = '0;
  logic [0:0]  entry_ins_state = '0;
  logic        rob_full;
  logic [3:0]  entry_id;
  logic        ex_done = 1'b0;
  logic [3:0]  ex_id = '0;
  logic [31:0] ex_reg_data = '0;
  logic        ex_pred_data = 1'b0;
  logic        wr_reg_en;
  logic [4:0]  wr_reg_addr;
  logic [31:0] wr_reg_data;
  logic        wr_pred_en;
  logic [2:0]  wr_pred_addr;
  logic        wr_pred_data;
  logic        rob_empty;

  int n_checks = 0;
  int n_fail   = 0;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .add_rob_entry(add_rob_entry), .entry_dest_addr(entry_dest_addr),
    .entry_ins_type(entry_ins_type), .entry_ins_state(entry_ins_state),
    .rob_full(rob_full), .entry_id(entry_id),
    .ex_done(ex_done), .ex_id(ex_id), .ex_reg_data(ex_reg_data), .ex_pred_data(ex_pred_data),
    .wr_reg_en(wr_reg_en), .wr_reg_addr(wr_reg_addr), .wr_reg_data(wr_reg_data),
    .wr_pred_en(wr_pred_en), .wr_pred_addr(wr_pred_addr), .wr_pred_data(wr_pred_data),
    .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding instructions in program order.
  typedef struct {
    int         id;
    bit         done;
    bit [1:0]   typ;
    bit [4:0]   dest;
    bit [31:0]  rdata;
    bit         pdata;
  } ent_t;

  typedef struct {
    bit        is_pred;
    bit [4:0]  addr;
    bit [31:0] data;
  } wr_t;

  ent_t model_q[$];
  int   next_id = 0;
  wr_t  exp_wr[$];
  wr_t  act_wr[$];

  function automatic bit m_commit();
    return model_q.size() > 0 && model_q[0].done;
  endfunction
  function automatic bit m_reg_en();
    return m_commit() && model_q[0].typ == 2'b10;
  endfunction
  function automatic bit m_pred_en();
    return m_commit() && model_q[0].typ == 2'b01;
  endfunction
  function automatic bit [4:0] m_dest();
    return model_q.size() > 0 ? model_q[0].dest : 5'd0;
  endfunction
  function automatic bit [31:0] m_rdata();
    return model_q.size() > 0 ? model_q[0].rdata : 32'd0;
  endfunction
  function automatic bit m_pdata();
    return model_q.size() > 0 ? model_q[0].pdata : 1'b0;
  endfunction

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_reg_en)  act_wr.push_back('{1'b0, wr_reg_addr, wr_reg_data});
      if (wr_pred_en) act_wr.push_back('{1'b1, {2'b00, wr_pred_addr}, {31'd0, wr_pred_data}});
    end
  end

  // Drives one cycle of inputs, advances the model across the edge, and returns #1 after it.
  task automatic applyStimulus(input bit rst, input bit add, input bit [4:0] dest,
                               input bit [1:0] typ, input bit state, input bit exd,
                               input bit [3:0] exid, input bit [31:0] data, input bit pdata);
    bit commit;
    int pre_size;
    reset = rst; add_rob_entry = add; entry_dest_addr = dest; entry_ins_type = typ;
    entry_ins_state = state; ex_done = exd; ex_id = exid; ex_reg_data = data;
    ex_pred_data = pdata;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      next_id = 0;
    end else begin
      commit   = m_commit();
      pre_size = model_q.size();
      if (exd)
        foreach (model_q[i])
          if (model_q[i].id == int'(exid) && !model_q[i].done) begin
            model_q[i].done  = 1'b1;
            model_q[i].rdata = data;
            model_q[i].pdata = pdata;
          end
      if (commit) begin
        ent_t e = model_q.pop_front();
        if (e.typ == 2'b10) exp_wr.push_back('{1'b0, e.dest, e.rdata});
        if (e.typ == 2'b01) exp_wr.push_back('{1'b1, {2'b00, e.dest[2:0]}, {31'd0, e.pdata}});
      end
      if (add && pre_size < 16) begin
        model_q.push_back('{next_id, state, typ, dest, 32'd0, 1'b0});
        next_id = (next_id + 1) % 16;
      end
    end
    #1;
    reset = 1'b0; add_rob_entry = 1'b0; ex_done = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (rob_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full got %b want 0", rob_full); end
    n_checks++; if (rob_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty got %b want 1", rob_empty); end
    n_checks++; if (entry_id !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_id got %0d want 0", entry_id); end
    n_checks++; if ({wr_reg_en, wr_pred_en} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_en got %b want 00", {wr_reg_en, wr_pred_en}); end
    n_checks++; if ({wr_reg_addr, wr_reg_data, wr_pred_addr, wr_pred_data} !== 41'd0) begin
      n_fail++; $display("[TB] FAIL reset_data got %h/%h/%h/%b want zeros", wr_reg_addr, wr_reg_data, wr_pred_addr, wr_pred_data);
    end
  endtask

  task automatic test_in_order();
    bit [4:0]  exp_addr [3];
    bit [31:0] exp_data [3];
    exp_addr = '{5'd5, 5'd6, 5'd7};
    exp_data = '{32'h10, 32'h20, 32'h30};
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (entry_id !== 4'(i)) begin n_fail++; $display("[TB] FAIL inorder_id got %0d want %0d", entry_id, i); end
      applyStimulus(0, 1, 5'(5 + i), 2'b10, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd2, 32'h30, 0);
    n_checks++; if (wr_reg_en !== 1'b0) begin n_fail++; $display("[TB] FAIL inorder_early got %b want 0", wr_reg_en); end
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd0, 32'h10, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({wr_reg_en, wr_reg_addr, wr_reg_data} !== {1'b1, exp_addr[i], exp_data[i]}) begin
        n_fail++;
        $display("[TB] FAIL inorder_write%0d got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                 i, wr_reg_en, wr_reg_addr, wr_reg_data, exp_addr[i], exp_data[i]);
      end
      if (i == 0) applyStimulus(0, 0, 0, 0, 0, 1, 4'd1, 32'h20, 0);
      else idle();
    end
    n_checks++; if ({wr_reg_en, rob_empty} !== 2'b01) begin n_fail++; $display("[TB] FAIL inorder_drain got %b want 01", {wr_reg_en, rob_empty}); end
  endtask

  task automatic test_full_wrap();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 5'(i), 2'b10, 0, 0, 0, 0, 0);
    n_checks++; if ({rob_full, rob_empty, entry_id} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("[TB] FAIL full_flags got full=%b empty=%b id=%0d want 1 0 0", rob_full, rob_empty, entry_id);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd0, 32'hAA, 0);
    n_checks++; if ({rob_full, wr_reg_en, wr_reg_data} !== {1'b1, 1'b1, 32'hAA}) begin
      n_fail++; $display("[TB] FAIL full_commit got full=%b en=%b data=%h want 1 1 aa", rob_full, wr_reg_en, wr_reg_data);
    end
    idle();
    n_checks++; if ({rob_full, entry_id} !== {1'b0, 4'd0}) begin
      n_fail++; $display("[TB] FAIL full_release got full=%b id=%0d want 0 0", rob_full, entry_id);
    end
    applyStimulus(0, 1, 5'd9, 2'b10, 0, 0, 0, 0, 0);
    n_checks++; if ({rob_full, entry_id} !== {1'b1, 4'd1}) begin
      n_fail++; $display("[TB] FAIL full_wrap got full=%b id=%0d want 1 1", rob_full, entry_id);
    end
  endtask

  task automatic test_pred();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5'd3, 2'b01, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd0, 32'hFFFF, 1);
    n_checks++; if ({wr_pred_en, wr_pred_addr, wr_pred_data, wr_reg_en} !== {1'b1, 3'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL pred_write got en=%b addr=%0d data=%b reg_en=%b want 1 3 1 0",
                         wr_pred_en, wr_pred_addr, wr_pred_data, wr_reg_en);
    end
    idle();
  endtask

  task automatic test_killed();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5'd12, 2'b00, 1, 0, 0, 0, 0);
    n_checks++; if ({rob_empty, wr_reg_en, wr_pred_en} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL killed_retire got %b want 000", {rob_empty, wr_reg_en, wr_pred_en});
    end
    idle();
    n_checks++; if (rob_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL killed_empty got %b want 1", rob_empty); end
  endtask

  task automatic test_back_to_back();
    int oldest;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_wr.delete(); act_wr.delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 5'($urandom), 2'b10, 0, 0, 0, 0, 0);
    oldest = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 1, 5'($urandom), $urandom_range(0, 1) ? 2'b10 : 2'b01, 0,
                    1, 4'(oldest), $urandom, 1'($urandom));
      oldest = (oldest + 1) % 16;
      if (c > 0) begin
        n_checks++;
        if ({wr_reg_en | wr_pred_en, rob_empty, rob_full} !== 3'b100 || entry_id !== 4'((c + 5) % 16)) begin
          n_fail++; $display("[TB] FAIL stream_cycle%0d got ret=%b empty=%b full=%b id=%0d want 1 0 0 %0d",
                             c, wr_reg_en | wr_pred_en, rob_empty, rob_full, entry_id, (c + 5) % 16);
        end
      end
    end
    n_checks++; if (act_wr.size() != 39) begin n_fail++; $display("[TB] FAIL stream_count got %0d want 39", act_wr.size()); end
    n_checks++; if (act_wr.size() != exp_wr.size()) begin
      n_fail++; $display("[TB] FAIL stream_log got %0d writes want %0d", act_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_checks++;
      if (act_wr[i] != exp_wr[i]) begin
        n_fail++; $display("[TB] FAIL stream_write%0d got p=%b a=%0d d=%h want p=%b a=%0d d=%h", i,
                           act_wr[i].is_pred, act_wr[i].addr, act_wr[i].data,
                           exp_wr[i].is_pred, exp_wr[i].addr, exp_wr[i].data);
      end
    end
  endtask

  task automatic test_random();
    bit       add, exd;
    bit [3:0] exid;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_wr.delete(); act_wr.delete();
    for (int c = 0; c < 300; c++) begin
      add = model_q.size() < 16 && ($urandom_range(0, 3) != 0);
      exd = $urandom_range(0, 9) < 7;
      if (model_q.size() > 0 && $urandom_range(0, 3) != 0)
        exid = 4'(model_q[$urandom_range(0, model_q.size() - 1)].id);
      else
        exid = 4'($urandom);
      if (add && int'(exid) == next_id) exd = 1'b0;
      applyStimulus(0, add, 5'($urandom), 2'($urandom), $urandom_range(0, 3) == 0,
                    exd, exid, $urandom, 1'($urandom));
      n_checks++;
      if ({rob_full, rob_empty, entry_id} !== {model_q.size() == 16, model_q.size() == 0, 4'(next_id)}) begin
        n_fail++; $display("[TB] FAIL rand_flags c=%0d got full=%b empty=%b id=%0d want %b %b %0d", c,
                           rob_full, rob_empty, entry_id, model_q.size() == 16, model_q.size() == 0, next_id);
      end
      n_checks++;
      if ({wr_reg_en, wr_pred_en} !== {m_reg_en(), m_pred_en()}) begin
        n_fail++; $display("[TB] FAIL rand_en c=%0d got %b%b want %b%b", c, wr_reg_en, wr_pred_en, m_reg_en(), m_pred_en());
      end
      n_checks++;
      if ({wr_reg_addr, wr_reg_data, wr_pred_addr, wr_pred_data} !== {m_dest(), m_rdata(), m_dest()[2:0], m_pdata()}) begin
        n_fail++; $display("[TB] FAIL rand_head c=%0d got %h/%h/%h/%b want %h/%h/%h/%b", c,
                           wr_reg_addr, wr_reg_data, wr_pred_addr, wr_pred_data,
                           m_dest(), m_rdata(), m_dest()[2:0], m_pdata());
      end
    end
    n_checks++; if (act_wr.size() != exp_wr.size()) begin
      n_fail++; $display("[TB] FAIL rand_log got %0d writes want %0d", act_wr.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 5'(20 + i), 2'b10, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({rob_full, rob_empty, entry_id, wr_reg_en, wr_pred_en, wr_reg_addr, wr_reg_data} !== {1'b0, 1'b1, 4'd0, 2'b00, 5'd0, 32'd0}) begin
      n_fail++; $display("[TB] FAIL midreset_state got full=%b empty=%b id=%0d en=%b%b addr=%0d data=%h want 0 1 0 00 0 0",
                         rob_full, rob_empty, entry_id, wr_reg_en, wr_pred_en, wr_reg_addr, wr_reg_data);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd1, 32'hDEAD, 1);
    applyStimulus(0, 1, 5'd1, 2'b10, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5'd2, 2'b10, 0, 0, 0, 0, 0);
    idle();
    n_checks++; if ({wr_reg_en, rob_empty, entry_id} !== {1'b0, 1'b0, 4'd2}) begin
      n_fail++; $display("[TB] FAIL midreset_stale got en=%b empty=%b id=%0d want 0 0 2", wr_reg_en, rob_empty, entry_id);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_pred();
    test_killed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
